// File: rtl/vend_coin_feeder.sv
// Payment-side initiator for the vending machine: picks a coin plan for a
// 3-rupee item, feeds it one coin per slot, then waits for Product/Change.
module vend_coin_feeder #(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] n_rs1,
    input  logic [3:0] n_rs2,
    input  logic       Product,
    input  logic       Change,
    output logic [1:0] coin,
    output logic       busy,
    output logic       done,
    output logic       got_product,
    output logic       got_change,
    output logic       err_timeout,
    output logic       insufficient,
    output logic [3:0] rem_rs1,
    output logic [3:0] rem_rs2,
    output logic [7:0] vend_count
);

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_RS1  = 2'b01;
    localparam logic [1:0] C_RS2  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_WAIT,
        ST_FIN
    } state_t;

    state_t          state;
    logic [2:0][1:0] plan;
    logic [1:0]      plan_len;
    logic [1:0]      idx;
    logic [2:0]      gap_cnt;
    logic [3:0]      wait_cnt;

    // Outputs are registered on the edge that enters a state, so each coin
    // is on the wire for exactly the SEND cycle that follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            plan         <= '0;
            plan_len     <= '0;
            idx          <= '0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
            coin         <= C_NONE;
            busy         <= 1'b0;
            done         <= 1'b0;
            got_product  <= 1'b0;
            got_change   <= 1'b0;
            err_timeout  <= 1'b0;
            insufficient <= 1'b0;
            rem_rs1      <= '0;
            rem_rs2      <= '0;
            vend_count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        got_product  <= 1'b0;
                        got_change   <= 1'b0;
                        err_timeout  <= 1'b0;
                        insufficient <= 1'b0;
                        busy         <= 1'b1;
                        idx          <= 2'd1;
                        rem_rs1      <= n_rs1;
                        rem_rs2      <= n_rs2;
                        state        <= ST_SEND;
                        if (n_rs2 != 4'd0 && n_rs1 != 4'd0) begin
                            plan     <= {C_NONE, C_RS1, C_RS2};
                            plan_len <= 2'd2;
                            coin     <= C_RS2;
                            rem_rs2  <= n_rs2 - 4'd1;
                        end else if (n_rs1 >= 4'd3) begin
                            plan     <= {C_RS1, C_RS1, C_RS1};
                            plan_len <= 2'd3;
                            coin     <= C_RS1;
                            rem_rs1  <= n_rs1 - 4'd1;
                        end else if (n_rs2 >= 4'd2) begin
                            plan     <= {C_NONE, C_RS2, C_RS2};
                            plan_len <= 2'd2;
                            coin     <= C_RS2;
                            rem_rs2  <= n_rs2 - 4'd1;
                        end else begin
                            plan         <= '0;
                            plan_len     <= 2'd0;
                            insufficient <= 1'b1;
                            state        <= ST_FIN;
                        end
                    end
                end

                ST_SEND: begin
                    coin <= C_NONE;
                    if (idx == plan_len) begin
                        wait_cnt <= 4'd0;
                        state    <= ST_WAIT;
                    end else begin
                        gap_cnt <= 3'd1;
                        state   <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == 3'(GAP)) begin
                        coin <= plan[idx];
                        if (plan[idx] == C_RS1)
                            rem_rs1 <= rem_rs1 - 4'd1;
                        else
                            rem_rs2 <= rem_rs2 - 4'd1;
                        idx   <= idx + 2'd1;
                        state <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end

                ST_WAIT: begin
                    if (Product) begin
                        got_product <= 1'b1;
                        got_change  <= Change;
                        vend_count  <= vend_count + 8'd1;
                        done        <= 1'b1;
                        state       <= ST_FIN;
                    end else if (wait_cnt == 4'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                ST_FIN: begin
                    // Arriving straight from IDLE (no plan) done is still low:
                    // spend one more FIN cycle so the pulse is still produced.
                    if (done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: begin
                    coin  <= C_NONE;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
